dataflow_switch_ctrl: RTL and testbench
=======================================

Name: dataflow_switch_ctrl

Overview:
- Sequential controller directly upstream of the DataFlow_Switch source mux; generates its select (drive DataFlow_Switch.i_state from o_state).
- Accepts a source-select request and changes o_state only at a safe boundary: both source A and source B idle for IDLE_CYCLES consecutive cycles. Downstream D-PHY TX never sees a mid-packet source change.
- Provides a forced-switch override, a post-switch settle window, a completion pulse and a stall timeout.

Parameters:
IDLE_CYCLES, 16, consecutive both-idle cycles required before toggling o_state (>=1)
SETTLE_CYCLES, 8, cycles held busy after a toggle before o_switch_done (>=1)
TIMEOUT_CYCLES, 4096, max cycles in WAIT_IDLE before abort (>IDLE_CYCLES)

Ports:
i_clk  in  1  system byte clock; all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_sel_req  in  1  requested source level, 0=A 1=B; synchronous to i_clk (upstream synchronizes)
i_force  in  1  switch at next edge regardless of idle while a request is pending
hs_clk_en_a  in  1  source A HS clock enable
hs_data_en_a  in  1  source A HS data enable
lp0_out_a  in  2  source A lane-0 LP state
hs_clk_en_b  in  1  source B HS clock enable
hs_data_en_b  in  1  source B HS data enable
lp0_out_b  in  2  source B lane-0 LP state
o_state  out  1  registered select to DataFlow_Switch i_state, 0=A 1=B
o_busy  out  1  high from request acceptance until switch complete
o_switch_done  out  1  one-cycle pulse on switch completion
o_timeout  out  1  one-cycle pulse on WAIT_IDLE abort

Behaviour:
- Interface: one clock, i_clk. Reset i_rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: o_state=0, o_busy=0, o_switch_done=0, o_timeout=0. State=RUN. Idle, timeout and settle counters=0. blocked=0.
- Reset asserted mid-operation returns immediately to source A (o_state=0), regardless of state or pending request.
- Source idle = hs_data_en_x==0 AND hs_clk_en_x==0 AND lp0_out_x==2'b11.
- both_idle = idle_A AND idle_B (combinational).
- Counter widths are $clog2 of the respective parameter +1. Counters saturate and never wrap.
- FSM states: RUN, WAIT_IDLE, SETTLE.
- RUN:
  - If i_sel_req != o_state and blocked==0: go to WAIT_IDLE, clear idle_cnt and to_cnt, set o_busy=1.
  - If i_force is also high at that edge: toggle o_state and go directly to SETTLE.
  - If i_sel_req == o_state: clear blocked.
- WAIT_IDLE, evaluated each edge in this priority order:
  1. Cancel: i_sel_req == o_state -> go to RUN, o_busy=0, no pulses.
  2. Force: i_force=1 -> toggle o_state, go to SETTLE.
  3. Idle complete: both_idle and idle_cnt+1 == IDLE_CYCLES -> toggle o_state, go to SETTLE. The toggle occurs exactly IDLE_CYCLES edges after entering WAIT_IDLE when both sources are continuously idle.
  4. Timeout: to_cnt+1 == TIMEOUT_CYCLES -> go to RUN, o_timeout=1 for one cycle, o_busy=0, o_state unchanged, blocked=1.
  5. Otherwise: idle_cnt = both_idle ? idle_cnt+1 : 0, and to_cnt increments.
- Any non-idle cycle restarts the idle count from 0.
- Idle completion on the same edge as timeout: the switch wins.
- SETTLE:
  - settle_cnt increments each edge. i_sel_req and i_force are ignored.
  - On the edge where settle_cnt+1 == SETTLE_CYCLES: go to RUN, o_busy=0, o_switch_done=1 for one cycle.
  - o_switch_done therefore rises SETTLE_CYCLES edges after the toggle edge.
  - A request still mismatching at RUN starts a new cycle on the next edge.
- i_force while no mismatch exists is ignored.
- blocked suppresses automatic re-entry after a timeout until i_sel_req matches o_state once.
- o_state changes only on the edges defined above; it never glitches.

Test Plan:
- Reset, then release with all sources idle → o_state=0, o_busy=0, no pulses for 100 cycles.
- IDLE=4, SETTLE=2; both sources idle; i_sel_req 0→1 sampled at edge E0 → o_busy=1 after E0, o_state=1 after E4, o_switch_done high only during the cycle after E6, o_busy=0 after E6.
- IDLE=4; hs_data_en_a pulses high for 1 cycle at the 3rd idle cycle of WAIT_IDLE → idle count restarts, o_state toggles 4 edges after that pulse ends.
- TIMEOUT=32; hs_data_en_a held 1; request to B → o_timeout pulses exactly 32 edges after WAIT_IDLE entry, o_state=0, no re-entry. Then i_sel_req→0 then →1 with idle sources → normal switch.
- Request to B with source A busy, i_force=1 at cycle 5 → o_state=1 at that edge, done after SETTLE_CYCLES. Separately: i_sel_req returns to 0 during WAIT_IDLE → back to RUN, no done, no timeout.
- Assert i_rst_n low during SETTLE with o_state=1 → o_state=0 and o_busy=0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/dataflow_switch_ctrl_if.sv
// Control/status bundle between the source-select requester and the switch
// controller: request inputs, per-source activity, and the registered select.
interface dataflow_switch_ctrl_if;
    logic       i_sel_req;
    logic       i_force;
    logic       hs_clk_en_a;
    logic       hs_data_en_a;
    logic [1:0] lp0_out_a;
    logic       hs_clk_en_b;
    logic       hs_data_en_b;
    logic [1:0] lp0_out_b;
    logic       o_state;
    logic       o_busy;
    logic       o_switch_done;
    logic       o_timeout;

    modport master (
        output i_sel_req, i_force,
        output hs_clk_en_a, hs_data_en_a, lp0_out_a,
        output hs_clk_en_b, hs_data_en_b, lp0_out_b,
        input  o_state, o_busy, o_switch_done, o_timeout
    );

    modport slave (
        input  i_sel_req, i_force,
        input  hs_clk_en_a, hs_data_en_a, lp0_out_a,
        input  hs_clk_en_b, hs_data_en_b, lp0_out_b,
        output o_state, o_busy, o_switch_done, o_timeout
    );
endinterface

// File: rtl/dataflow_switch_ctrl.sv
// Source-select controller for the DataFlow_Switch mux: moves o_state only once
// both sources have been idle long enough, with force, settle and timeout paths.
module dataflow_switch_ctrl #(
    parameter int IDLE_CYCLES    = 16,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    dataflow_switch_ctrl_if.slave sw
);
    localparam int IW = $clog2(IDLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int SW = $clog2(SETTLE_CYCLES) + 1;

    typedef enum logic [1:0] {RUN, WAIT_IDLE, SETTLE} fsm_e;

    fsm_e          fsm_q, fsm_d;
    logic          state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic          blocked_q, blocked_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;

    logic          idle_a, idle_b, both_idle, mismatch;
    logic [IW-1:0] idle_inc;
    logic [TW-1:0] to_inc;
    logic [SW-1:0] settle_inc;

    assign idle_a    = !sw.hs_data_en_a && !sw.hs_clk_en_a && (sw.lp0_out_a == 2'b11);
    assign idle_b    = !sw.hs_data_en_b && !sw.hs_clk_en_b && (sw.lp0_out_b == 2'b11);
    assign both_idle = idle_a && idle_b;
    assign mismatch  = (sw.i_sel_req != state_q);

    // Saturating increments; the terminal compares fire before saturation is reached.
    assign idle_inc   = (idle_cnt_q   == '1) ? idle_cnt_q   : idle_cnt_q   + IW'(1);
    assign to_inc     = (to_cnt_q     == '1) ? to_cnt_q     : to_cnt_q     + TW'(1);
    assign settle_inc = (settle_cnt_q == '1) ? settle_cnt_q : settle_cnt_q + SW'(1);

    always_comb begin
        fsm_d        = fsm_q;
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        blocked_d    = blocked_q;
        idle_cnt_d   = idle_cnt_q;
        to_cnt_d     = to_cnt_q;
        settle_cnt_d = settle_cnt_q;
        case (fsm_q)
            RUN: begin
                if (mismatch && !blocked_q) begin
                    busy_d       = 1'b1;
                    idle_cnt_d   = '0;
                    to_cnt_d     = '0;
                    settle_cnt_d = '0;
                    if (sw.i_force) begin
                        state_d = ~state_q;
                        fsm_d   = SETTLE;
                    end else begin
                        fsm_d   = WAIT_IDLE;
                    end
                end else if (!mismatch) begin
                    blocked_d = 1'b0;
                end
            end
            WAIT_IDLE: begin
                // Cancel beats force beats idle completion beats timeout.
                if (!mismatch) begin
                    fsm_d  = RUN;
                    busy_d = 1'b0;
                end else if (sw.i_force || (both_idle && idle_inc == IW'(IDLE_CYCLES))) begin
                    state_d      = ~state_q;
                    fsm_d        = SETTLE;
                    settle_cnt_d = '0;
                end else if (to_inc == TW'(TIMEOUT_CYCLES)) begin
                    fsm_d     = RUN;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    blocked_d = 1'b1;
                end else begin
                    idle_cnt_d = both_idle ? idle_inc : '0;
                    to_cnt_d   = to_inc;
                end
            end
            SETTLE: begin
                if (settle_inc == SW'(SETTLE_CYCLES)) begin
                    fsm_d        = RUN;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_inc;
                end
            end
            default: begin
                fsm_d  = RUN;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q        <= RUN;
            state_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            blocked_q    <= 1'b0;
            idle_cnt_q   <= '0;
            to_cnt_q     <= '0;
            settle_cnt_q <= '0;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            blocked_q    <= blocked_d;
            idle_cnt_q   <= idle_cnt_d;
            to_cnt_q     <= to_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign sw.o_state       = state_q;
    assign sw.o_busy        = busy_q;
    assign sw.o_switch_done = done_q;
    assign sw.o_timeout     = timeout_q;
endmodule

// File: tb/tb_dataflow_switch_ctrl.sv
// Randomized and directed checks of dataflow_switch_ctrl against a cycle-level
// reference model built from the switching rules.
module tb_dataflow_switch_ctrl;
    localparam int IDLE    = 4;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 32;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    dataflow_switch_ctrl_if bus();

    dataflow_switch_ctrl #(
        .IDLE_CYCLES   (IDLE),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .sw     (bus)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: mode 0=running, 1=waiting for idle, 2=settling.
    int   m_mode, m_streak, m_age, m_settle_left;
    logic m_st, m_busy, m_done, m_to, m_blk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic src_idle(input logic ce, input logic de, input logic [1:0] lp);
        return !ce && !de && lp == 2'b11;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_streak = 0; m_age = 0; m_settle_left = 0;
        m_st = 0; m_busy = 0; m_done = 0; m_to = 0; m_blk = 0;
    endtask

    task automatic model_edge();
        logic bidle, want;
        bidle = src_idle(bus.hs_clk_en_a, bus.hs_data_en_a, bus.lp0_out_a) &&
                src_idle(bus.hs_clk_en_b, bus.hs_data_en_b, bus.lp0_out_b);
        want  = bus.i_sel_req;
        m_done = 0;
        m_to   = 0;
        if (m_mode == 0) begin
            if (want != m_st && !m_blk) begin
                m_busy = 1;
                if (bus.i_force) begin
                    m_st = ~m_st; m_mode = 2; m_settle_left = SETTLE;
                end else begin
                    m_mode = 1; m_streak = 0; m_age = 0;
                end
            end else if (want == m_st) m_blk = 0;
        end else if (m_mode == 1) begin
            m_age++;
            if (want == m_st) begin
                m_mode = 0; m_busy = 0;
            end else if (bus.i_force || (bidle && m_streak + 1 >= IDLE)) begin
                m_st = ~m_st; m_mode = 2; m_settle_left = SETTLE;
            end else if (m_age >= TIMEOUT) begin
                m_mode = 0; m_busy = 0; m_to = 1; m_blk = 1;
            end else begin
                m_streak = bidle ? m_streak + 1 : 0;
            end
        end else begin
            m_settle_left--;
            if (m_settle_left == 0) begin
                m_mode = 0; m_busy = 0; m_done = 1;
            end
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
        chk("o_state", bus.o_state, m_st);
        chk("o_busy", bus.o_busy, m_busy);
        chk("o_switch_done", bus.o_switch_done, m_done);
        chk("o_timeout", bus.o_timeout, m_to);
    endtask

    task automatic drive_src(input bit busy_a, input bit busy_b);
        bus.hs_clk_en_a = 0; bus.hs_data_en_a = busy_a; bus.lp0_out_a = 2'b11;
        bus.hs_clk_en_b = 0; bus.hs_data_en_b = busy_b; bus.lp0_out_b = 2'b11;
    endtask

    task automatic rand_src(output logic ce, output logic de, output logic [1:0] lp, input int pct);
        ce = 0; de = 0; lp = 2'b11;
        if ($urandom_range(99) < pct) begin
            case ($urandom_range(2))
                0: ce = 1;
                1: de = 1;
                default: lp = 2'($urandom_range(2));
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 0;
        bus.i_sel_req = 0; bus.i_force = 0;
        drive_src(0, 0);
        #1;
        chk("rst_state", bus.o_state, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_switch_done, 0);
        chk("rst_timeout", bus.o_timeout, 0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        model_reset();
        i_rst_n = 1;
    endtask

    initial begin
        model_reset();
        bus.i_sel_req = 0; bus.i_force = 0;
        drive_src(0, 0);
        do_reset();
        repeat (100) step();

        // Basic switch with idle sources: toggle after 4 edges, done 2 later.
        bus.i_sel_req = 1;
        step();
        chk("sw_busy_e0", bus.o_busy, 1);
        repeat (3) step();
        chk("sw_state_e3", bus.o_state, 0);
        step();
        chk("sw_state_e4", bus.o_state, 1);
        step();
        chk("sw_done_e5", bus.o_switch_done, 0);
        step();
        chk("sw_done_e6", bus.o_switch_done, 1);
        chk("sw_busy_e6", bus.o_busy, 0);
        repeat (5) step();

        // Activity on the 3rd idle cycle restarts the idle count.
        do_reset();
        bus.i_sel_req = 1;
        repeat (3) step();
        drive_src(1, 0);
        step();
        drive_src(0, 0);
        repeat (3) step();
        chk("restart_state_3", bus.o_state, 0);
        step();
        chk("restart_state_4", bus.o_state, 1);
        repeat (4) step();

        // Timeout with source A busy, then blocked until request matches once.
        do_reset();
        drive_src(1, 0);
        bus.i_sel_req = 1;
        repeat (32) step();
        chk("to_pre", bus.o_timeout, 0);
        step();
        chk("to_pulse", bus.o_timeout, 1);
        chk("to_state", bus.o_state, 0);
        drive_src(0, 0);
        repeat (6) step();
        chk("to_blocked", bus.o_busy, 0);
        bus.i_sel_req = 0;
        step();
        bus.i_sel_req = 1;
        repeat (8) step();
        chk("to_recover", bus.o_state, 1);

        // Forced switch while source A is busy.
        do_reset();
        drive_src(1, 0);
        bus.i_sel_req = 1;
        repeat (5) step();
        bus.i_force = 1;
        step();
        chk("force_state", bus.o_state, 1);
        bus.i_force = 0;
        repeat (4) step();

        // Cancel during the idle wait.
        do_reset();
        drive_src(1, 0);
        bus.i_sel_req = 1;
        repeat (3) step();
        bus.i_sel_req = 0;
        step();
        chk("cancel_busy", bus.o_busy, 0);
        repeat (40) step();

        // Asynchronous reset during settle.
        do_reset();
        bus.i_sel_req = 1; bus.i_force = 1;
        step();
        chk("ar_state_pre", bus.o_state, 1);
        bus.i_force = 0; bus.i_sel_req = 0;
        #2 i_rst_n = 0;
        #1;
        chk("ar_state", bus.o_state, 0);
        chk("ar_busy", bus.o_busy, 0);
        @(negedge i_clk);
        model_reset();
        i_rst_n = 1;
        repeat (3) step();

        // Random traffic with varying source noise.
        for (int blk = 0; blk < 15; blk++) begin
            int pct;
            pct = (blk % 3 == 0) ? 0 : (blk % 3 == 1) ? 5 : 30;
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(19) == 0) bus.i_sel_req = ~bus.i_sel_req;
                bus.i_force = ($urandom_range(24) == 0);
                rand_src(bus.hs_clk_en_a, bus.hs_data_en_a, bus.lp0_out_a, pct);
                rand_src(bus.hs_clk_en_b, bus.hs_data_en_b, bus.lp0_out_b, pct);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
